// File: rtl/lzw_pkg.sv
// Shared LZW datapath defaults and the packer FSM state encoding.
package lzw_pkg;
  localparam int LZW_CODE_WIDTH = 12;
  localparam int LZW_BYTE_WIDTH = 8;

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_e;
endpackage

// File: rtl/code_packer_if.sv
// Code-in / byte-out handshake bundle; slave is the packer, master the surrounding logic.
interface code_packer_if
  import lzw_pkg::*;
#(
  parameter int CODE_WIDTH = LZW_CODE_WIDTH,
  parameter int BYTE_WIDTH = LZW_BYTE_WIDTH
);
  logic                  iCodeValid;
  logic [CODE_WIDTH-1:0] iCode;
  logic                  oCodeReady;
  logic                  iFlush;
  logic                  oByteValid;
  logic [BYTE_WIDTH-1:0] oByte;
  logic                  iByteReady;
  logic                  oFlushDone;
  logic [15:0]           oByteCount;

  modport master (
    output iCodeValid, iCode, iFlush, iByteReady,
    input  oCodeReady, oByteValid, oByte, oFlushDone, oByteCount
  );

  modport slave (
    input  iCodeValid, iCode, iFlush, iByteReady,
    output oCodeReady, oByteValid, oByte, oFlushDone, oByteCount
  );
endinterface

// File: rtl/code_packer.sv
// Packs fixed-width LZW codes into an MSB-first byte stream; flush drains and zero-pads.
module code_packer
  import lzw_pkg::*;
#(
  parameter int CODE_WIDTH = LZW_CODE_WIDTH,
  parameter int BYTE_WIDTH = LZW_BYTE_WIDTH
) (
  input logic          Clk,
  input logic          Reset,
  code_packer_if.slave bus
);
  localparam int ACC_W = CODE_WIDTH + BYTE_WIDTH;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] BW_C = CNT_W'(BYTE_WIDTH);
  localparam logic [CNT_W-1:0] CW_C = CNT_W'(CODE_WIDTH);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_sh;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_sh;
  logic [15:0]        bcnt_q, bcnt_d;
  logic               byte_valid, code_ready, emit, accept;

  always_comb begin
    byte_valid = 1'b0;
    case (state_q)
      RUN:     byte_valid = (cnt_q >= BW_C);
      FLUSH:   byte_valid = (cnt_q != '0);
      default: byte_valid = 1'b0;
    endcase
    code_ready = (state_q == RUN) && (cnt_q <= BW_C);
    emit       = byte_valid && bus.iByteReady;
    accept     = bus.iCodeValid && code_ready;

    // The emit shift happens first so an accepted code lands right below the surviving bits.
    acc_sh = emit ? (acc_q << BYTE_WIDTH) : acc_q;
    cnt_sh = cnt_q;
    if (emit) cnt_sh = (cnt_q >= BW_C) ? (cnt_q - BW_C) : '0;

    acc_d = acc_sh;
    cnt_d = cnt_sh;
    if (accept) begin
      acc_d = acc_sh | ({bus.iCode, {BYTE_WIDTH{1'b0}}} >> cnt_sh);
      cnt_d = cnt_sh + CW_C;
    end
    bcnt_d = bcnt_q + 16'(emit);

    state_d = state_q;
    case (state_q)
      RUN:     if (bus.iFlush) state_d = FLUSH;
      FLUSH:   if (cnt_d == '0) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign bus.oCodeReady = code_ready;
  assign bus.oByteValid = byte_valid;
  assign bus.oByte      = acc_q[ACC_W-1 -: BYTE_WIDTH];
  assign bus.oFlushDone = (state_q == DONE);
  assign bus.oByteCount = bcnt_q;
endmodule

// File: tb/tb_code_packer.sv
// Directed bench for code_packer with a bit-queue reference model checked every cycle.
module tb_code_packer;
  localparam int CW = 12;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  code_packer_if #(.CODE_WIDTH(CW), .BYTE_WIDTH(BW)) bus ();
  code_packer #(.CODE_WIDTH(CW), .BYTE_WIDTH(BW)) dut (.Clk(clk), .Reset(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: pending bits as a queue, mode 0=run 1=flush 2=done.
  bit          mq[$];
  int          mmode = 0;
  logic [15:0] mcount = '0;

  int          cyc = 0;
  logic [7:0]  got[$];
  int          done_n = 0, done_cyc = 0, last_emit_cyc = 0, flush_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [7:0] eb;
    bit ev, er;
    for (int i = 0; i < 8; i++) begin
      if (i < mq.size()) eb[7-i] = mq[i];
      else eb[7-i] = 1'b0;
    end
    ev = (mmode == 0) ? (mq.size() >= 8) : (mmode == 1) ? (mq.size() > 0) : 1'b0;
    er = (mmode == 0) && (mq.size() <= 8);
    chk("m_ready", bus.oCodeReady, er);
    chk("m_valid", bus.oByteValid, ev);
    chk("m_byte", bus.oByte, eb);
    chk("m_done", bus.oFlushDone, mmode == 2);
    chk("m_count", bus.oByteCount, mcount);

    if (bus.oFlushDone) begin done_n++; done_cyc = cyc; end
    if (bus.oByteValid && bus.iByteReady) begin got.push_back(bus.oByte); last_emit_cyc = cyc; end
    if (bus.iFlush && mmode == 0 && !rst) flush_cyc = cyc;

    if (rst) begin
      mq.delete(); mmode = 0; mcount = '0;
    end else begin
      if (ev && bus.iByteReady) begin
        for (int k = 0; k < 8; k++) if (mq.size() > 0) void'(mq.pop_front());
        mcount = mcount + 16'd1;
      end
      if (er && bus.iCodeValid)
        for (int k = CW - 1; k >= 0; k--) mq.push_back(bus.iCode[k]);
      case (mmode)
        0: if (bus.iFlush) mmode = 1;
        1: if (mq.size() == 0) mmode = 2;
        default: mmode = 0;
      endcase
    end
  end

  task automatic send(input logic [11:0] c);
    bit ok = 1'b0;
    bus.iCodeValid = 1'b1;
    bus.iCode = c;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = bus.oCodeReady;
      @(posedge clk); #1;
    end
    bus.iCodeValid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic pulse_flush();
    bus.iFlush = 1'b1;
    @(posedge clk); #1;
    bus.iFlush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // exp holds n bytes, first byte in the most significant used position.
  task automatic chk_seq(input string nm, input int n, input logic [63:0] exp);
    chk({nm, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk($sformatf("%s_b%0d", nm, i), got[i], exp[8*(n-1-i) +: 8]);
  endtask

  initial begin
    bus.iCodeValid = 1'b0; bus.iCode = '0; bus.iFlush = 1'b0; bus.iByteReady = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.oCodeReady, 1);
    chk("rst_valid", bus.oByteValid, 0);
    chk("rst_count", bus.oByteCount, 0);
    @(posedge clk); #1;

    // two codes, no backpressure
    got.delete();
    send(12'hABC); send(12'h123); idle(5);
    chk_seq("two_codes", 3, 64'hABC123);
    chk("two_codes_count", bus.oByteCount, 3);
    chk("two_codes_empty", bus.oByteValid, 0);

    // partial-byte flush
    got.delete(); done_n = 0;
    send(12'hABC); pulse_flush(); idle(6);
    chk_seq("partial", 2, 64'hABC0);
    chk("partial_done_n", done_n, 1);
    chk("partial_done_lat", done_cyc - last_emit_cyc, 1);

    // flush while empty
    got.delete(); done_n = 0;
    pulse_flush(); idle(5);
    chk("empty_bytes", got.size(), 0);
    chk("empty_done_n", done_n, 1);
    chk("empty_done_lat", done_cyc - flush_cyc, 2);

    // backpressure with toggling ready
    got.delete();
    fork
      begin send(12'hFFF); send(12'h000); send(12'h5A5); pulse_flush(); end
      begin
        repeat (30) begin bus.iByteReady = ~bus.iByteReady; @(posedge clk); #1; end
        bus.iByteReady = 1'b1;
      end
    join
    idle(8);
    chk_seq("bp", 5, 64'hFFF0005A50);

    // accept + emit + flush in the same cycle at cnt 8
    got.delete();
    send(12'hABC); send(12'h123); idle(1);
    bus.iCodeValid = 1'b1; bus.iCode = 12'h456; bus.iFlush = 1'b1;
    @(negedge clk);
    chk("sim_ready", bus.oCodeReady, 1);
    chk("sim_valid", bus.oByteValid, 1);
    @(posedge clk); #1;
    bus.iCodeValid = 1'b0; bus.iFlush = 1'b0;
    idle(8);
    chk_seq("sim", 5, 64'hABC1234560);

    // reset during a stalled flush holding 12 bits
    bus.iByteReady = 1'b0; done_n = 0;
    send(12'hABC); pulse_flush();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_ready", bus.oCodeReady, 1);
    chk("rst_mid_valid", bus.oByteValid, 0);
    chk("rst_mid_byte", bus.oByte, 0);
    chk("rst_mid_done", bus.oFlushDone, 0);
    chk("rst_mid_count", bus.oByteCount, 0);
    bus.iByteReady = 1'b1;
    idle(5);
    chk("rst_mid_no_done", done_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
